conv_unit_scheduler: RTL and testbench

Sequences a bank of N_UNITS convUnit instances, which have no start/done pins and are started by releasing their active-high reset.
- Splits a job of num_windows filter windows into groups of up to N_UNITS.
- For each group: requests window loading, runs the active units for exactly LATENCY cycles and captures their results.
- Streams the captured results downstream one per valid/ready handshake, tagged with the global window index.

---
 rtl/conv_sched_pkg.sv | 23 ++
 rtl/conv_result_serializer.sv | 58 +++++
 rtl/conv_unit_scheduler.sv | 132 +++++++++++++
 tb/tb_conv_unit_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convUnit bank scheduler.
// Holds the FSM state encoding, the default unit latency and a constant clog2.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam int DEFAULT_F       = 5;
  localparam int DEFAULT_LATENCY = DEFAULT_F * DEFAULT_F + 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_result_serializer.sv
// Captures one group of unit results and streams them out over valid/ready,
// each tagged with its global window index (base + position in group).
module conv_result_serializer
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_UNITS    = 14,
  parameter int IDX_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          capture,
  input  logic [N_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [IDX_W-1:0]              active,
  input  logic [IDX_W-1:0]              base,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_index,
  output logic                          last_accept
);

  localparam int K_W = (clog2(N_UNITS) < 1) ? 1 : clog2(N_UNITS);

  logic [DATA_WIDTH-1:0] shadow [N_UNITS];
  logic [K_W-1:0]        k;
  logic                  accept;

  assign accept      = out_valid && out_ready;
  assign last_accept = accept && (IDX_W'(k) == active - 1'b1);

  // NOTE: the shadow bank carries no reset; out_data is masked by out_valid,
  // so stale contents can never reach the port.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int u = 0; u < N_UNITS; u++) begin
        shadow[u] <= unit_result[u*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      k         <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      k         <= '0;
    end else if (accept) begin
      if (last_accept) out_valid <= 1'b0;
      else             k         <= k + 1'b1;
    end
  end

  assign out_data  = out_valid ? shadow[k] : '0;
  assign out_index = out_valid ? base + IDX_W'(k) : '0;

endmodule

// File: rtl/conv_unit_scheduler.sv
// Sequences a bank of reset-started convUnits: loads a group of windows, holds
// the active units out of reset for LATENCY cycles, then drains their results.
module conv_unit_scheduler
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_UNITS    = 14,
  parameter int F          = 5,
  parameter int LATENCY    = F * F + 2,
  parameter int IDX_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IDX_W-1:0]              num_windows,
  output logic                          busy,
  output logic                          done,
  output logic                          load_req,
  output logic [IDX_W-1:0]              group_base,
  input  logic                          load_ack,
  output logic [N_UNITS-1:0]            unit_reset,
  input  logic [N_UNITS*DATA_WIDTH-1:0] unit_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_index
);

  localparam int                CNT_W    = (clog2(LATENCY) < 1) ? 1 : clog2(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0]  UNITS    = IDX_W'(N_UNITS);

  state_t             state, state_next;
  logic [IDX_W-1:0]   remaining, base, active, active_next;
  logic [CNT_W-1:0]   cnt;
  logic [N_UNITS-1:0] run_mask;
  logic               capture, last_accept;

  assign active_next = (remaining > UNITS) ? UNITS : remaining;

  always_comb begin
    run_mask = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      run_mask[u] = (IDX_W'(u) < active_next);
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = (num_windows != '0) ? LOAD : FIN;
      LOAD:  if (load_ack) state_next = RUN;
      RUN: begin
        if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end
      end
      // remaining - active == 0 exactly when this was the final group
      DRAIN: if (last_accept) state_next = (remaining != active) ? LOAD : FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
  // active-low, and abandons any job in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      base       <= '0;
      active     <= '0;
      cnt        <= '0;
      unit_reset <= '1;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && num_windows != '0) begin
            remaining <= num_windows;
            base      <= '0;
          end
        end
        LOAD: begin
          if (load_ack) begin
            cnt        <= '0;
            active     <= active_next;
            unit_reset <= ~run_mask;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (capture) unit_reset <= '1;
        end
        DRAIN: begin
          if (last_accept) begin
            remaining <= remaining - active;
            base      <= base + active;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign load_req   = (state == LOAD);
  assign group_base = base;

  conv_result_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_UNITS    (N_UNITS),
    .IDX_W      (IDX_W)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .unit_result (unit_result),
    .active      (active),
    .base        (base),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_index   (out_index),
    .last_accept (last_accept)
  );

endmodule

// File: tb/tb_conv_unit_scheduler.sv
// Self-checking bench: behavioural convUnit bank plus an upstream/downstream model,
// with a scoreboard of expected (index, result) pairs popped on each accept.
module tb_conv_unit_scheduler;

  localparam int DW  = 16;
  localparam int NU  = 14;
  localparam int FS  = 5;
  localparam int LAT = FS * FS + 2;
  localparam int IW  = 16;

  logic              clk = 1'b0;
  logic              reset, start, load_ack, out_ready;
  logic [IW-1:0]     num_windows;
  logic              busy, done, load_req, out_valid;
  logic [IW-1:0]     group_base, out_index;
  logic [NU-1:0]     unit_reset;
  logic [NU*DW-1:0]  unit_result;
  logic [DW-1:0]     out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_unit_scheduler #(
    .DATA_WIDTH (DW),
    .N_UNITS    (NU),
    .F          (FS),
    .LATENCY    (LAT),
    .IDX_W      (IW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_windows (num_windows),
    .busy        (busy),
    .done        (done),
    .load_req    (load_req),
    .group_base  (group_base),
    .load_ack    (load_ack),
    .unit_reset  (unit_reset),
    .unit_result (unit_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            accepts = 0;
  logic [IW-1:0] win_base = '0;
  int            ucnt[NU];
  int            low_n[NU];

  // Window 0 is the all-0x4400 case: 25 * (4.0 * 4.0) = 400.0 = 0x5E40.
  function automatic logic [DW-1:0] win_val(input logic [IW-1:0] w);
    return 16'h5E40 + DW'(w * 16'h0137);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural convUnit: result is only meaningful after LAT-1 clocks out of reset.
  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) ucnt[k] <= unit_reset[k] ? 0 : ucnt[k] + 1;
  end

  always_comb begin
    unit_result = '0;
    for (int k = 0; k < NU; k++) begin
      unit_result[k*DW +: DW] = (!unit_reset[k] && ucnt[k] >= LAT - 1)
                                ? win_val(win_base + IW'(k)) : 16'hDEAD;
    end
  end

  // Each unit_reset low pulse must last exactly LAT cycles.
  always @(negedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (!reset) low_n[k] = 0;
      else if (!unit_reset[k]) low_n[k]++;
      else if (low_n[k] != 0) begin
        check("unit_low_cycles", low_n[k], LAT);
        low_n[k] = 0;
      end
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_index", out_index, prev_idx);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check("out_index", out_index, mon_e.idx);
          check("out_data", out_data, mon_e.data);
          accepts++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
  end

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (load_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_req", load_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_unit_reset", unit_reset, 14'h3FFF);
    check("rst_group_base", group_base, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
  endtask

  task automatic run_job(input int n, input int ack_delay, input bit stall, input bit start_in_run);
    int            base, rem, act, acc0, target;
    bit            ok, stalled;
    logic [NU-1:0] mask;
    base    = 0;
    rem     = n;
    acc0    = accepts;
    stalled = 1'b0;
    num_windows = IW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (n == 0) begin
      check("zero_load_req", load_req, 0);
      check("zero_done", done, 1);
      check("zero_unit_reset", unit_reset, 14'h3FFF);
      tick();
      check("zero_done_pulse", done, 0);
      check("zero_busy_low", busy, 0);
      return;
    end
    while (rem > 0) begin
      wait_load(ok);
      check("load_req_seen", ok, 1);
      if (!ok) return;
      check("group_base", group_base, base);
      act = (rem < NU) ? rem : NU;
      for (int d = 0; d < ack_delay; d++) begin
        check("pre_ack_unit_reset", unit_reset, 14'h3FFF);
        tick();
      end
      win_base = IW'(base);
      for (int i = 0; i < act; i++) sb.push_back('{idx: IW'(base + i), data: win_val(IW'(base + i))});
      load_ack = 1'b1;
      tick();
      load_ack = 1'b0;
      mask = '1;
      mask = mask << act;
      check("load_req_drop", load_req, 0);
      check("run_unit_reset", unit_reset, mask);
      if (start_in_run) begin
        num_windows = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_windows = IW'(n);
      end
      target = acc0 + base + act;
      for (int c = 0; c < 400 && accepts < target; c++) begin
        if (stall && !stalled && out_valid && out_index == IW'(base + 3)) begin
          out_ready = 1'b0;
          repeat (5) tick();
          out_ready = 1'b1;
          stalled = 1'b1;
        end
        tick();
      end
      check("group_drained", accepts, target);
      if (accepts != target) return;
      rem  -= act;
      base += act;
    end
    check("done_pulse", done, 1);
    check("busy_in_fin", busy, 1);
    check("accepts_at_done", accepts - acc0, n);
    tick();
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
    check("valid_cleared", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int extra;
    reset = 1'b0;
    start = 1'b0;
    load_ack = 1'b0;
    out_ready = 1'b1;
    num_windows = '0;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();

    run_job(1, 0, 1'b0, 1'b0);
    run_job(30, 2, 1'b1, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    run_job(4, 10, 1'b0, 1'b1);

    extra = 0;
    for (int c = 0; c < 40; c++) begin
      if (load_req || busy || done) extra++;
      tick();
    end
    check("ignored_start_no_job", extra, 0);

    num_windows = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_load(ok);
    check("abort_load_req", ok, 1);
    win_base = '0;
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs();
    reset = 1'b1;
    sb.delete();
    tick();
    check("abort_no_resume", load_req, 0);

    run_job(3, 1, 1'b0, 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
